// File: rtl/booth_mul_arbiter_if.sv
// Request/multiplier/response bundle between the Booth multiplier arbiter and its neighbours.
// The arbiter uses the slave modport. Clients, the multiplier and the response consumer use master.
interface booth_mul_arbiter_if #(
  parameter int W = 8
);
  logic                  req0_valid;
  logic                  req0_ready;
  logic signed [W-1:0]   req0_a;
  logic signed [W-1:0]   req0_b;
  logic                  req1_valid;
  logic                  req1_ready;
  logic signed [W-1:0]   req1_a;
  logic signed [W-1:0]   req1_b;
  logic                  mul_load;
  logic signed [W-1:0]   mul_a;
  logic signed [W-1:0]   mul_b;
  logic signed [2*W-1:0] mul_prod;
  logic                  rsp_valid;
  logic                  rsp_ready;
  logic signed [2*W-1:0] rsp_prod;
  logic                  rsp_id;
  logic                  busy;

  modport slave (
    input  req0_valid, req0_a, req0_b,
    input  req1_valid, req1_a, req1_b,
    input  mul_prod, rsp_ready,
    output req0_ready, req1_ready,
    output mul_load, mul_a, mul_b,
    output rsp_valid, rsp_prod, rsp_id, busy
  );

  modport master (
    output req0_valid, req0_a, req0_b,
    output req1_valid, req1_a, req1_b,
    output mul_prod, rsp_ready,
    input  req0_ready, req1_ready,
    input  mul_load, mul_a, mul_b,
    input  rsp_valid, rsp_prod, rsp_id, busy
  );
endinterface

// File: rtl/booth_mul_arbiter.sv
// Two-port arbiter and sequencer for one shared serial Booth multiplier with a fixed latency.
// Define BOOTH_ARB_RR_EN for round-robin arbitration. Without it, requester 0 wins every tie.
module booth_mul_arbiter #(
  parameter int W       = 8,
  parameter int MUL_LAT = 4
) (
  input  logic                clk,
  input  logic                rst,
  booth_mul_arbiter_if.slave  bus
);

  localparam int CNT_W = $clog2(MUL_LAT + 1);
  localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(MUL_LAT - 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_LOAD,
    S_WAIT,
    S_DONE
  } state_t;

  state_t                state_q;
  state_t                state_d;
  logic [CNT_W-1:0]      cnt_q;
  logic                  grant;
  logic                  accept;
  logic                  idle_ok;
  logic                  mul_load_c;
  logic                  rsp_valid_c;
  logic                  busy_c;
  logic                  capture;

  logic signed [W-1:0]   a_p0;
  logic signed [W-1:0]   b_p0;
  logic                  id_p0;
  logic signed [2*W-1:0] prod_p1;
  logic                  id_p1;

`ifdef BOOTH_ARB_RR_EN
  logic                  ptr_q;

  always_comb begin
    grant = bus.req1_valid;
    if (bus.req0_valid && bus.req1_valid)
      grant = ptr_q;
  end

  // The pointer moves to the requester that lost, so it wins the next tie.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)
      ptr_q <= 1'b0;
    else if (accept)
      ptr_q <= ~grant;
  end
`else
  always_comb begin
    grant = bus.req1_valid && !bus.req0_valid;
  end
`endif

  // The ready lines are gated by rst, so nothing is accepted while reset is held.
  assign idle_ok        = (state_q == S_IDLE) && !rst;
  assign bus.req0_ready = idle_ok && bus.req0_valid && !grant;
  assign bus.req1_ready = idle_ok && bus.req1_valid && grant;
  assign accept         = bus.req0_ready || bus.req1_ready;
  assign capture        = (state_q == S_WAIT) && (cnt_q == '0);

  always_ff @(posedge clk or posedge rst) begin
    if (rst)
      state_q <= S_IDLE;
    else
      state_q <= state_d;
  end

  always_comb begin
    state_d     = state_q;
    mul_load_c  = 1'b0;
    rsp_valid_c = 1'b0;
    busy_c      = 1'b1;
    unique case (state_q)
      S_IDLE: begin
        busy_c = 1'b0;
        if (accept)
          state_d = S_LOAD;
      end
      S_LOAD: begin
        mul_load_c = 1'b1;
        state_d    = S_WAIT;
      end
      S_WAIT: begin
        if (cnt_q == '0)
          state_d = S_DONE;
      end
      S_DONE: begin
        rsp_valid_c = 1'b1;
        if (bus.rsp_ready)
          state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst)
      cnt_q <= '0;
    else if (state_q == S_LOAD)
      cnt_q <= CNT_LOAD;
    else if ((state_q == S_WAIT) && (cnt_q != '0))
      cnt_q <= cnt_q - CNT_W'(1);
  end

  // Stage p0: the operands and owner are latched at accept.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      a_p0  <= '0;
      b_p0  <= '0;
      id_p0 <= 1'b0;
    end else if (accept) begin
      a_p0  <= grant ? bus.req1_a : bus.req0_a;
      b_p0  <= grant ? bus.req1_b : bus.req0_b;
      id_p0 <= grant;
    end
  end

  // Stage p1: the product is captured on the edge where the multiplier's result is valid.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      prod_p1 <= '0;
      id_p1   <= 1'b0;
    end else if (capture) begin
      prod_p1 <= bus.mul_prod;
      id_p1   <= id_p0;
    end
  end

  assign bus.mul_load  = mul_load_c;
  assign bus.mul_a     = a_p0;
  assign bus.mul_b     = b_p0;
  assign bus.rsp_valid = rsp_valid_c;
  assign bus.rsp_prod  = prod_p1;
  assign bus.rsp_id    = id_p1;
  assign bus.busy      = busy_c;

endmodule

// File: doc/booth_mul_arbiter.md
# booth_mul_arbiter

Sequencer and two-port arbiter for the shared 8-bit radix-4 Booth multiplier (serial PISO, recoder and accumulator datapath). It accepts operand pairs from two requesters over valid/ready handshakes and grants one requester at a time. It issues the single-cycle `load` pulse with operands to the multiplier, waits out the multiplier's fixed latency, captures the 16-bit product, and returns it with the requester ID over a valid/ready response channel. It sits between the client blocks and one multiplier instance, so the multiplier is never reloaded mid-operation.

## Interface
- `W`, default 8: operand width; product width is 2W.
- `MUL_LAT`, default 4: cycles from the edge that samples `mul_load` to the edge that samples `mul_prod`. Minimum 1. Integration sets it to the attached multiplier's latency.

Ports:
- `clk` in 1: single clock, rising edge.
- `rst` in 1: asynchronous, active-high reset.
- `req0_valid` in 1: requester 0 has an operand pair.
- `req0_ready` out 1: requester 0 accepted this cycle.
- `req0_a` in W: multiplicand, two's complement.
- `req0_b` in W: multiplier, two's complement.
- `req1_valid`, `req1_ready`, `req1_a`, `req1_b`: same as requester 0, for requester 1.
- `mul_load` out 1: one-cycle load pulse to the multiplier.
- `mul_a` out W: multiplicand to the multiplier.
- `mul_b` out W: multiplier operand to the multiplier.
- `mul_prod` in 2W: multiplier product.
- `rsp_valid` out 1: response available.
- `rsp_ready` in 1: consumer accepts the response.
- `rsp_prod` out 2W: captured product.
- `rsp_id` out 1: requester that owns the response.
- `busy` out 1: high in every state except IDLE.

## Operation
- FSM states are IDLE, LOAD, WAIT and DONE. A down-counter `cnt` of width ceil(log2(MUL_LAT+1)) times WAIT.
- **IDLE**
  - The grant goes to the single valid requester. If both are valid, the grant follows the priority rule (see Configuration).
  - Only the granted requester's `ready` is high, combinationally from its `valid`. At most one `ready` is high in any cycle.
  - On accept: latch a, b and ID into internal registers, go to LOAD.
- **LOAD**
  - `mul_load`=1; `mul_a`/`mul_b` driven from the latched operands.
  - Set `cnt`=MUL_LAT−1, go to WAIT.
- **WAIT**
  - `mul_load`=0; `mul_a`/`mul_b` hold the latched operands.
  - Decrement `cnt` each cycle. On the cycle where `cnt`=0: `rsp_prod`<=`mul_prod`, `rsp_id`<=latched ID, go to DONE.
- **DONE**
  - `rsp_valid`=1. `rsp_prod` and `rsp_id` are stable until `rsp_valid && rsp_ready`, then go to IDLE.
  - Requester `ready` lines stay low throughout.
- Arithmetic: the block does no arithmetic on data. Products pass through unmodified, sign included.
- Requesters may drop `valid` without being accepted. No hold requirement is imposed.

## Timing
- Reset values: state IDLE, all `ready` lines 0, `mul_load` 0, `mul_a`/`mul_b` 0, `rsp_valid` 0, `rsp_prod` 0, `rsp_id` 0, `busy` 0, priority pointer 0, `cnt` 0.
- Accept at edge k gives:
  - `mul_load` high for exactly cycle k..k+1;
  - `mul_prod` sampled at edge k+1+MUL_LAT;
  - `rsp_valid` high from that edge onward.
- Minimum accept-to-`rsp_valid` latency is MUL_LAT+1 cycles, so 5 at the default.
- A response handshake at edge m returns the FSM to IDLE. The earliest next accept is edge m+1. Minimum issue interval is MUL_LAT+3 cycles.
- `mul_load` is never asserted while `busy` was already high before LOAD. The multiplier is never re-loaded during WAIT or DONE.
- Reset asserted in any state:
  - the FSM returns to IDLE asynchronously;
  - the in-flight operation is discarded with no response;
  - the pointer is cleared to 0.
- Reset release with `valid` already high: the accept may occur at the first rising edge after deassertion.

## Configuration
- `BOOTH_ARB_RR_EN` defined: round-robin arbitration.
  - The 1-bit priority pointer toggles to the non-granted requester on every accept.
  - On simultaneous requests the pointer's requester wins.
- Not defined: fixed priority, requester 0 always wins on a tie. The pointer is not implemented.

## Test plan
- **Single request.** req0 issues a=0xDA (−38), b=0x37 (55). Required response: `rsp_prod`=0xF7D6 (−2090) and `rsp_id`=0, with `rsp_valid` at accept+5 cycles. `mul_load` is exactly one cycle wide.
- **Simultaneous requests, RR_EN defined.** Both requesters valid:
  - req0: a=22, b=107;
  - req1: a=0x9D (−99), b=91.
  - Required: req0 is served first with 0x0932, then req1 with 0xDCCF. `req1_ready` stays low until the first response handshake completes.
- **Simultaneous requests, RR_EN undefined.** Both requesters held valid for 3 operations. Required: only req0 is accepted each time, and `req1_ready` is never high.
- **Response backpressure.** req1 issues a=78, b=0xAE (−82), with `rsp_ready` low for 10 cycles. Required:
  - `rsp_valid`, `rsp_prod`=0xE704 and `rsp_id`=1 are held stable throughout;
  - no `ready` is raised and no `mul_load` is pulsed;
  - after the handshake, the next accept occurs no earlier than the following edge.
- **Reset mid-operation.** Assert `rst` during WAIT. Required: all outputs return to their reset values immediately, no response is ever produced, and a subsequent a=0, b=0 request returns 0x0000.
